// File: rtl/hir_mac_pipe_if.sv
// Issue/result bundle for hir_mac_pipe: operands and control in, result, valid and overflow out.
// The producer/consumer side uses master; the MAC unit uses slave.
interface hir_mac_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 64
);
  logic                 t;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 acc_en;
  logic                 acc_clr;
  logic [ACC_WIDTH-1:0] result;
  logic                 result_valid;
  logic                 acc_ovf;

  modport master (
    output t, a, b, acc_en, acc_clr,
    input  result, result_valid, acc_ovf
  );

  modport slave (
    input  t, a, b, acc_en, acc_clr,
    output result, result_valid, acc_ovf
  );
endinterface

// File: rtl/hir_mac_pipe.sv
// Fully pipelined multiply / multiply-accumulate unit with a fixed issue-to-result latency.
// Operands are captured on issue, multiplied across the middle stages and folded into the accumulator in the last stage.
module hir_mac_pipe #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 64,
  parameter int LATENCY   = 3,
  parameter int SIGNED    = 1
) (
  input  logic           clk,
  input  logic           rst,
  hir_mac_pipe_if.slave  bus
);
  localparam int PW  = 2 * WIDTH;
  localparam int MSB = ACC_WIDTH - 1;

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("hir_mac_pipe: WIDTH must be >= 1");
    end
    if (ACC_WIDTH < PW) begin : g_bad_acc_width
      $error("hir_mac_pipe: ACC_WIDTH must be >= 2*WIDTH");
    end
    if (LATENCY < 1) begin : g_bad_latency
      $error("hir_mac_pipe: LATENCY must be >= 1");
    end
  endgenerate

  function automatic logic [ACC_WIDTH-1:0] ext_product(input logic [WIDTH-1:0] x,
                                                       input logic [WIDTH-1:0] y);
    logic signed [PW-1:0] sx;
    logic signed [PW-1:0] sy;
    logic        [PW-1:0] p;
    if (SIGNED != 0) begin
      sx = PW'($signed(x));
      sy = PW'($signed(y));
      p  = sx * sy;
      return ACC_WIDTH'($signed(p));
    end else begin
      p = PW'(x) * PW'(y);
      return ACC_WIDTH'(p);
    end
  endfunction

  logic [WIDTH-1:0]     a_r, b_r;
  logic                 v0_r, en0_r, clr0_r;
  logic [ACC_WIDTH-1:0] prod_s;
  logic [ACC_WIDTH-1:0] fin_prod_s;
  logic                 fin_v_s, fin_en_s, fin_clr_s;

  // Issue stage: operands load only on t so idle-cycle garbage never reaches the multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      v0_r   <= 1'b0;
      en0_r  <= 1'b0;
      clr0_r <= 1'b0;
    end else begin
      v0_r <= bus.t;
      if (bus.t) begin
        a_r    <= bus.a;
        b_r    <= bus.b;
        en0_r  <= bus.acc_en;
        clr0_r <= bus.acc_clr;
      end
    end
  end

  assign prod_s = ext_product(a_r, b_r);

  generate
    if (LATENCY == 1) begin : g_single
      assign fin_prod_s = prod_s;
      assign fin_v_s    = v0_r;
      assign fin_en_s   = en0_r;
      assign fin_clr_s  = clr0_r;
    end else begin : g_chain
      logic [ACC_WIDTH-1:0] pp_r [1:LATENCY-1];
      logic [LATENCY-1:1]   pv_r, pe_r, pc_r;

      // Product and control travel together through the intermediate stages.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 1; i < LATENCY; i++) begin
            pp_r[i] <= '0;
          end
          pv_r <= '0;
          pe_r <= '0;
          pc_r <= '0;
        end else begin
          pp_r[1] <= prod_s;
          pv_r[1] <= v0_r;
          pe_r[1] <= en0_r;
          pc_r[1] <= clr0_r;
          for (int i = 2; i < LATENCY; i++) begin
            pp_r[i] <= pp_r[i-1];
            pv_r[i] <= pv_r[i-1];
            pe_r[i] <= pe_r[i-1];
            pc_r[i] <= pc_r[i-1];
          end
        end
      end

      assign fin_prod_s = pp_r[LATENCY-1];
      assign fin_v_s    = pv_r[LATENCY-1];
      assign fin_en_s   = pe_r[LATENCY-1];
      assign fin_clr_s  = pc_r[LATENCY-1];
    end
  endgenerate

  logic [ACC_WIDTH-1:0] acc_r, res_r;
  logic                 valid_r, ovf_r;
  logic [ACC_WIDTH:0]   sum_ext_s;
  logic                 ovf_det_s;
  logic [ACC_WIDTH-1:0] acc_nxt_s, res_nxt_s;
  logic                 ovf_nxt_s;

  // Final stage: all accumulator reads and writes happen here, so back-to-back accumulates never race.
  always_comb begin
    sum_ext_s = {1'b0, acc_r} + {1'b0, fin_prod_s};
    if (SIGNED != 0) begin
      ovf_det_s = (acc_r[MSB] == fin_prod_s[MSB]) && (sum_ext_s[MSB] != acc_r[MSB]);
    end else begin
      ovf_det_s = sum_ext_s[ACC_WIDTH];
    end
    acc_nxt_s = acc_r;
    res_nxt_s = res_r;
    ovf_nxt_s = ovf_r;
    if (fin_v_s) begin
      if (!fin_en_s) begin
        res_nxt_s = fin_prod_s;
      end else if (fin_clr_s) begin
        acc_nxt_s = fin_prod_s;
        res_nxt_s = fin_prod_s;
        ovf_nxt_s = 1'b0;
      end else begin
        acc_nxt_s = sum_ext_s[MSB:0];
        res_nxt_s = sum_ext_s[MSB:0];
        ovf_nxt_s = ovf_r | ovf_det_s;
      end
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // Accumulator and registered outputs; result holds between valid pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r   <= '0;
      res_r   <= '0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      acc_r   <= acc_nxt_s;
      res_r   <= res_nxt_s;
      valid_r <= fin_v_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign bus.result       = res_r;
  assign bus.result_valid = valid_r;
  assign bus.acc_ovf      = ovf_r;
endmodule

// File: tb/tb_hir_mac_pipe.sv
// Self-checking bench: five hir_mac_pipe configurations share one stimulus stream and are compared
// every cycle against an arithmetic scoreboard; directed sequences add fixed-value checks.
module tb_hir_mac_pipe;
  localparam int NCFG = 5;
  localparam int LAT_P [0:NCFG-1] = '{3, 1, 1, 5, 5};
  localparam int SG_P  [0:NCFG-1] = '{1, 0, 1, 0, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        t, acc_en, acc_clr;
  logic [31:0] a, b;

  logic [63:0] res_w [NCFG];
  logic        rv_w  [NCFG];
  logic        ovf_w [NCFG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    hir_mac_pipe_if #(.WIDTH(32), .ACC_WIDTH(64)) bus ();
    assign bus.t       = t;
    assign bus.a       = a;
    assign bus.b       = b;
    assign bus.acc_en  = acc_en;
    assign bus.acc_clr = acc_clr;
    assign res_w[g]    = bus.result;
    assign rv_w[g]     = bus.result_valid;
    assign ovf_w[g]    = bus.acc_ovf;

    hir_mac_pipe #(.WIDTH(32), .ACC_WIDTH(64), .LATENCY(LAT_P[g]), .SIGNED(SG_P[g])) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  // Scoreboard: expected outcome slot per (config, edge index mod 8), plus what the outputs currently show.
  bit          sl_v   [NCFG][8];
  logic [63:0] sl_res [NCFG][8];
  bit          sl_ovf [NCFG][8];
  logic [63:0] m_acc  [NCFG];
  bit          m_ovf  [NCFG];
  logic [63:0] sh_res [NCFG];
  bit          sh_ovf [NCFG];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, k);
    end
  endtask

  function automatic logic [63:0] ref_prod(input bit sg, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (sg) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end else begin
      return {32'h0, x} * {32'h0, y};
    end
  endfunction

  function automatic bit ref_ovf(input bit sg, input logic [63:0] x, input logic [63:0] y);
    logic signed [64:0] s;
    logic        [64:0] u;
    if (sg) begin
      s = 65'($signed(x)) + 65'($signed(y));
      return (s > 65'sd9223372036854775807) || (s < -65'sd9223372036854775808);
    end else begin
      u = {1'b0, x} + {1'b0, y};
      return u > 65'h0_FFFF_FFFF_FFFF_FFFF;
    end
  endfunction

  task automatic model_reset();
    for (int g = 0; g < NCFG; g++) begin
      for (int s = 0; s < 8; s++) sl_v[g][s] = 1'b0;
      m_acc[g]  = 64'h0;
      m_ovf[g]  = 1'b0;
      sh_res[g] = 64'h0;
      sh_ovf[g] = 1'b0;
    end
  endtask

  task automatic model_issue(input logic [31:0] aa, input logic [31:0] bb, input bit en, input bit clr);
    logic [63:0] p, r;
    int idx;
    for (int g = 0; g < NCFG; g++) begin
      p = ref_prod(SG_P[g] != 0, aa, bb);
      if (!en) begin
        r = p;
      end else if (clr) begin
        m_acc[g] = p;
        m_ovf[g] = 1'b0;
        r = p;
      end else begin
        if (ref_ovf(SG_P[g] != 0, m_acc[g], p)) m_ovf[g] = 1'b1;
        m_acc[g] = m_acc[g] + p;
        r = m_acc[g];
      end
      idx = (k + 1 + LAT_P[g]) % 8;
      sl_v[g][idx]   = 1'b1;
      sl_res[g][idx] = r;
      sl_ovf[g][idx] = m_ovf[g];
    end
  endtask

  task automatic model_check();
    int idx;
    idx = k % 8;
    for (int g = 0; g < NCFG; g++) begin
      if (sl_v[g][idx]) begin
        sh_res[g] = sl_res[g][idx];
        sh_ovf[g] = sl_ovf[g][idx];
        sl_v[g][idx] = 1'b0;
        chk($sformatf("c%0d_valid", g), 64'(rv_w[g]), 64'h1);
      end else begin
        chk($sformatf("c%0d_valid", g), 64'(rv_w[g]), 64'h0);
      end
      chk($sformatf("c%0d_result", g), res_w[g], sh_res[g]);
      chk($sformatf("c%0d_ovf", g), 64'(ovf_w[g]), 64'(sh_ovf[g]));
    end
  endtask

  // One clock: inputs for the next edge, then sample after that edge.
  task automatic drive(input bit tt, input logic [31:0] aa, input logic [31:0] bb, input bit en, input bit clr);
    t = tt; a = aa; b = bb; acc_en = en; acc_clr = clr;
    if (tt) model_issue(aa, bb, en, clr);
    @(negedge clk);
    k++;
    model_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; t = 1'b0; a = 32'h0; b = 32'h0; acc_en = 1'b0; acc_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("c%0d_rst_result", g), res_w[g], 64'h0);
      chk($sformatf("c%0d_rst_valid", g), 64'(rv_w[g]), 64'h0);
      chk($sformatf("c%0d_rst_ovf", g), 64'(ovf_w[g]), 64'h0);
    end
    rst = 1'b0;
    k = 0;

    // Plain signed multiply, three-cycle latency.
    drive(1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    idle(2);
    chk("t1_valid_early", 64'(rv_w[0]), 64'h0);
    idle(1);
    chk("t1_result", res_w[0], 64'hFFFF_FFFF_FFFF_FFEB);
    chk("t1_valid", 64'(rv_w[0]), 64'h1);
    chk("t1_ovf", 64'(ovf_w[0]), 64'h0);
    idle(5);

    // Back-to-back accumulate chain.
    drive(1'b1, 32'd2, 32'd3, 1'b1, 1'b1);
    drive(1'b1, 32'd4, 32'd5, 1'b1, 1'b0);
    drive(1'b1, 32'hFFFF_FFFF, 32'd10, 1'b1, 1'b0);
    drive(1'b1, 32'd6, 32'd6, 1'b1, 1'b0);
    chk("t2_r0", res_w[0], 64'd6);
    chk("t2_v0", 64'(rv_w[0]), 64'h1);
    idle(1);
    chk("t2_r1", res_w[0], 64'd26);
    chk("t2_v1", 64'(rv_w[0]), 64'h1);
    idle(1);
    chk("t2_r2", res_w[0], 64'd16);
    idle(1);
    chk("t2_r3", res_w[0], 64'd52);
    chk("t2_v3", 64'(rv_w[0]), 64'h1);
    idle(1);
    chk("t2_hold", res_w[0], 64'd52);
    chk("t2_v_off", 64'(rv_w[0]), 64'h0);
    idle(5);

    // Unsigned full-width product (LATENCY=1, SIGNED=0 instance).
    drive(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    idle(1);
    chk("t3_result", res_w[1], 64'h0000_0001_FFFF_FFFE);
    chk("t3_valid", 64'(rv_w[1]), 64'h1);
    idle(5);

    // Signed accumulator overflow and its clearing.
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    drive(1'b1, 32'd1, 32'd1, 1'b1, 1'b1);
    chk("t4_clr_res", res_w[0], 64'h4000_0000_0000_0000);
    chk("t4_clr_ovf", 64'(ovf_w[0]), 64'h0);
    idle(1);
    chk("t4_acc1_res", res_w[0], 64'h8000_0000_0000_0000);
    chk("t4_acc1_ovf", 64'(ovf_w[0]), 64'h1);
    idle(1);
    chk("t4_acc2_res", res_w[0], 64'hC000_0000_0000_0000);
    chk("t4_sticky", 64'(ovf_w[0]), 64'h1);
    idle(1);
    chk("t4_reclr_res", res_w[0], 64'd1);
    chk("t4_reclr_ovf", 64'(ovf_w[0]), 64'h0);
    idle(5);

    // Asynchronous reset with an op in flight.
    drive(1'b1, 32'd5, 32'd6, 1'b0, 1'b0);
    idle(1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_res", res_w[0], 64'h0);
    chk("t5_async_valid", 64'(rv_w[0]), 64'h0);
    model_reset();
    idle(1);
    rst = 1'b0;
    idle(1);
    chk("t5_no_valid", 64'(rv_w[0]), 64'h0);
    drive(1'b1, 32'd7, 32'd8, 1'b0, 1'b0);
    idle(3);
    chk("t5_after_res", res_w[0], 64'd56);
    chk("t5_after_valid", 64'(rv_w[0]), 64'h1);
    idle(5);

    // Random traffic against the scoreboard on every configuration.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 3) != 0), pick(), pick(), 1'($urandom), ($urandom_range(0, 3) == 0));
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
